// File: rtl/data_memory_access_unit_if.sv
// Bundle between the EX/MEM stage, the data memory and the load/store access unit.
// Latency: none, wires only.
// Backpressure: the slave drives stall back toward the pipeline side.
// Ports: master = pipeline + memory side (drives requests and memory read data),
//        slave  = access unit (drives memory strobes, load result, stall, fault).
interface data_memory_access_unit_if #(
    parameter int data_bits = 32
);
    logic                 mem_read_in;
    logic                 mem_write_in;
    logic [2:0]           funct3_in;
    logic [data_bits-1:0] alu_result_in;
    logic [data_bits-1:0] store_data_in;
    logic                 flush;
    logic [data_bits-3:0] address;
    logic [data_bits-1:0] input_data;
    logic                 write_enable;
    logic                 read_enable;
    logic [data_bits-1:0] output_data;
    logic [data_bits-1:0] load_data;
    logic                 load_valid;
    logic                 stall;
    logic                 misaligned_fault;

    modport master (
        output mem_read_in, mem_write_in, funct3_in, alu_result_in, store_data_in,
               flush, output_data,
        input  address, input_data, write_enable, read_enable, load_data,
               load_valid, stall, misaligned_fault
    );

    modport slave (
        input  mem_read_in, mem_write_in, funct3_in, alu_result_in, store_data_in,
               flush, output_data,
        output address, input_data, write_enable, read_enable, load_data,
               load_valid, stall, misaligned_fault
    );
endinterface

// File: rtl/data_memory_access_unit.sv
// Load/store unit: byte/half/word accesses onto a word-addressed synchronous data memory.
// Latency: word store 1 cycle; loads and sub-word stores (read-modify-write) 2 cycles.
// Backpressure: stall asserted in the request cycle of every 2-cycle access; requests held upstream.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the EX/MEM request,
//        the memory address/write data/strobes/read data, load result, stall and fault pulse.
module data_memory_access_unit #(
    parameter int data_bits = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    data_memory_access_unit_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2
    } state_t;

    localparam logic [data_bits-1:0] byte_ones = {{(data_bits-8){1'b0}}, 8'hFF};
    localparam logic [data_bits-1:0] half_ones = {{(data_bits-16){1'b0}}, 16'hFFFF};

    state_t state;

    logic [1:0]           lane;
    logic [2:0]           f3;
    logic                 req;
    logic                 legal;
    logic                 word_acc;
    logic                 half_acc;
    logic                 misalign;
    logic                 fault_req;
    logic                 in_idle;
    logic                 go;
    logic                 sub_store;
    logic [4:0]           shamt;
    logic [data_bits-1:0] lane_ones;
    logic [data_bits-1:0] merged;
    logic [data_bits-1:0] shifted;
    logic [data_bits-1:0] extracted;

    assign lane = bus.alu_result_in[1:0];
    assign f3   = bus.funct3_in;

    // Request decode and fault qualification
    always_comb begin
        req       = bus.mem_read_in | bus.mem_write_in;
        legal     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        word_acc  = (f3 == 3'b010);
        half_acc  = (f3[1:0] == 2'b01);
        misalign  = (half_acc && lane[0]) || (word_acc && (lane != 2'b00));
        fault_req = req && ((bus.mem_read_in && bus.mem_write_in) || !legal || misalign);
        // flush in IDLE swallows the request entirely, fault included
        in_idle   = rst_n && (state == IDLE) && !bus.flush;
        go        = in_idle && req && !fault_req;
        sub_store = bus.mem_write_in && !word_acc;
    end

    // Lane shift: halfwords sit at bit 0 or 16, bytes at 0/8/16/24.
    // The same shift serves the store merge and the load extraction.
    always_comb begin
        shamt     = half_acc ? {lane[1], 4'b0000} : {lane, 3'b000};
        lane_ones = half_acc ? half_ones : byte_ones;
        merged    = (bus.output_data & ~(lane_ones << shamt)) |
                    ((bus.store_data_in & lane_ones) << shamt);
        shifted   = bus.output_data >> shamt;
        case (f3)
            3'b000:  extracted = {{(data_bits-8){shifted[7]}}, shifted[7:0]};
            3'b100:  extracted = {{(data_bits-8){1'b0}}, shifted[7:0]};
            3'b001:  extracted = {{(data_bits-16){shifted[15]}}, shifted[15:0]};
            3'b101:  extracted = {{(data_bits-16){1'b0}}, shifted[15:0]};
            default: extracted = bus.output_data;
        endcase
    end

    // Outputs are combinational from state and inputs; every strobe is gated by
    // rst_n so nothing leaks while reset is held with a request on the inputs.
    always_comb begin
        bus.address          = bus.alu_result_in[data_bits-1:2];
        bus.read_enable      = go && (bus.mem_read_in || sub_store);
        bus.stall            = go && (bus.mem_read_in || sub_store);
        bus.misaligned_fault = in_idle && fault_req;
        bus.write_enable     = (go && bus.mem_write_in && word_acc) ||
                               (rst_n && (state == RMW_MERGE) && !bus.flush);
        bus.load_valid       = rst_n && (state == LOAD_WAIT) && !bus.flush;
        bus.input_data       = (state == RMW_MERGE) ? merged : bus.store_data_in;
        bus.load_data        = bus.load_valid ? extracted : '0;
    end

    // Every 2-cycle access returns to IDLE after its second cycle, flushed or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (go && bus.mem_read_in)
                        state <= LOAD_WAIT;
                    else if (go && sub_store)
                        state <= RMW_MERGE;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_access_unit.sv
module tb_data_memory_access_unit;

    localparam int DB = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_access_unit_if #(.data_bits(DB)) bus();

    data_memory_access_unit #(.data_bits(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous one-cycle-latency data memory, 256 words
    logic [31:0] tb_mem [0:255];
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (bus.read_enable)  rdata <= tb_mem[bus.address[7:0]];
        if (bus.write_enable) tb_mem[bus.address[7:0]] <= bus.input_data;
    end
    assign bus.output_data = rdata;

    // Reference memory image kept by the model
    logic [31:0] ref_mem [0:255];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef enum {EV_LOAD, EV_WRITE, EV_FAULT} ev_t;
    typedef struct {
        ev_t         kind;
        logic [31:0] waddr;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    // ---------------- reference model ----------------
    function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        if (!(rd || wr)) return 1'b0;
        if (rd && wr) return 1'b1;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = ref_mem[a[9:2]];
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] d);
        logic [31:0] w;
        w = ref_mem[a[9:2]];
        if (f3[1:0] == 2'b00)      w[8*a[1:0] +: 8]  = d[7:0];
        else if (f3[1:0] == 2'b01) w[16*a[1] +: 16]  = d[15:0];
        else                       w = d;
        return w;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        int   n;
        if (rst_n) begin
            if (!bus.load_valid) chk("load_data_zero_when_invalid", bus.load_data, 32'd0);
            n = int'(bus.load_valid) + int'(bus.write_enable) + int'(bus.misaligned_fault);
            if (n != 0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: lv=%b we=%b mf=%b, scoreboard empty at %0t",
                             bus.load_valid, bus.write_enable, bus.misaligned_fault, $time);
                end else begin
                    e = q.pop_front();
                    case (e.kind)
                        EV_LOAD: begin
                            chk("event_kind_load", {bus.load_valid, bus.write_enable, bus.misaligned_fault}, 32'b100);
                            chk("load_data", bus.load_data, e.data);
                            chk("load_stall_low", {31'd0, bus.stall}, 32'd0);
                        end
                        EV_WRITE: begin
                            chk("event_kind_write", {bus.load_valid, bus.write_enable, bus.misaligned_fault}, 32'b010);
                            chk("write_addr", {2'b00, bus.address}, e.waddr);
                            chk("write_data", bus.input_data, e.data);
                        end
                        default: begin
                            chk("event_kind_fault", {bus.load_valid, bus.write_enable, bus.misaligned_fault}, 32'b001);
                            chk("fault_strobes_low", {bus.read_enable, bus.write_enable, bus.stall}, 32'd0);
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Entered just after a rising edge; leaves just after the edge that ends the access.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   flt;
        bit   s;
        int   exp_stall;
        int   stalls;
        flt = model_fault(rd, wr, f3, a);
        if (flt) begin
            e = '{EV_FAULT, 32'd0, 32'd0};
            q.push_back(e);
        end else if (rd) begin
            e = '{EV_LOAD, a >> 2, model_load(f3, a)};
            q.push_back(e);
        end else if (wr) begin
            e = '{EV_WRITE, a >> 2, model_store(f3, a, d)};
            ref_mem[a[9:2]] = e.data;
            q.push_back(e);
        end
        exp_stall = (!flt && (rd || (wr && f3 != 3'd2))) ? 1 : 0;

        bus.mem_read_in   = rd;
        bus.mem_write_in  = wr;
        bus.funct3_in     = f3;
        bus.alu_result_in = a;
        bus.store_data_in = d;
        #1;
        chk("address", {2'b00, bus.address}, a >> 2);
        chk("read_enable", {31'd0, bus.read_enable}, exp_stall);

        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s = bus.stall;
            if (s) stalls++;
            @(posedge clk);
            #1;
            if (!s) break;
        end
        chk("stall_cycles", stalls, exp_stall);
        bus.mem_read_in  = 1'b0;
        bus.mem_write_in = 1'b0;
    endtask

    // Start an access, then abort it in its second cycle with flush or reset.
    task automatic abort_access(input bit rd, input bit use_reset, input logic [31:0] a);
        bus.mem_read_in   = rd;
        bus.mem_write_in  = !rd;
        bus.funct3_in     = 3'd0;
        bus.alu_result_in = a;
        bus.store_data_in = 32'h0000_0077;
        #1;
        chk("abort_first_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            chk("reset_abort_outputs",
                {bus.write_enable, bus.read_enable, bus.load_valid, bus.stall, bus.misaligned_fault}, 32'd0);
            chk("reset_abort_load_data", bus.load_data, 32'd0);
            bus.mem_read_in  = 1'b0;
            bus.mem_write_in = 1'b0;
            @(negedge clk);
            #1;
            rst_n = 1'b1;
        end else begin
            bus.flush = 1'b1;
            #1;
            chk("flush_abort_outputs",
                {bus.write_enable, bus.load_valid, bus.stall}, 32'd0);
            chk("flush_abort_load_data", bus.load_data, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.flush        = 1'b0;
        bus.mem_read_in  = 1'b0;
        bus.mem_write_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bit          rd, wr;
        int          r;
        int          legal_f3 [5] = '{0, 1, 2, 4, 5};

        bus.mem_read_in   = 1'b1;
        bus.mem_write_in  = 1'b0;
        bus.funct3_in     = 3'd2;
        bus.alu_result_in = 32'h100;
        bus.store_data_in = 32'd0;
        bus.flush         = 1'b0;
        #1;
        chk("reset_strobes",
            {bus.read_enable, bus.write_enable, bus.stall, bus.load_valid, bus.misaligned_fault}, 32'd0);
        chk("reset_load_data", bus.load_data, 32'd0);
        bus.mem_read_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the memory through word stores so model and memory agree
        for (int i = 0; i < 256; i++) issue(1'b0, 1'b1, 3'd2, i * 4, $urandom);

        // Directed cases
        issue(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        issue(1'b0, 1'b1, 3'd2, 32'h100, 32'h80FF7F01);
        issue(1'b1, 1'b0, 3'd0, 32'h103, 32'd0);
        issue(1'b1, 1'b0, 3'd4, 32'h103, 32'd0);
        issue(1'b1, 1'b0, 3'd1, 32'h100, 32'd0);
        issue(1'b1, 1'b0, 3'd5, 32'h102, 32'd0);
        issue(1'b0, 1'b1, 3'd2, 32'h100, 32'hAABBCCDD);
        issue(1'b0, 1'b1, 3'd1, 32'h102, 32'h00001234);
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        issue(1'b0, 1'b1, 3'd2, 32'h100, 32'hAABBCCDD);
        issue(1'b0, 1'b1, 3'd0, 32'h101, 32'h00000055);
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        issue(1'b0, 1'b1, 3'd2, 32'h104, 32'h01020304);
        issue(1'b1, 1'b0, 3'd2, 32'h101, 32'd0);
        issue(1'b0, 1'b1, 3'd1, 32'h103, 32'h1);
        issue(1'b1, 1'b0, 3'd3, 32'h100, 32'd0);
        issue(1'b1, 1'b1, 3'd2, 32'h100, 32'd0);

        // flush in IDLE swallows both a legal and an illegal request
        bus.flush = 1'b1;
        bus.mem_read_in = 1'b1;
        bus.mem_write_in = 1'b1;
        bus.funct3_in = 3'd2;
        bus.alu_result_in = 32'h100;
        #1;
        chk("flush_idle_illegal", {bus.read_enable, bus.write_enable, bus.stall, bus.misaligned_fault}, 32'd0);
        bus.mem_write_in = 1'b0;
        #1;
        chk("flush_idle_load", {bus.read_enable, bus.write_enable, bus.stall, bus.misaligned_fault}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.mem_read_in = 1'b0;

        // Aborted sub-word stores and loads leave memory intact and the unit reusable
        abort_access(1'b0, 1'b0, 32'h101);
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        abort_access(1'b0, 1'b1, 32'h102);
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        abort_access(1'b1, 1'b0, 32'h103);
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        abort_access(1'b1, 1'b1, 32'h100);
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            rd = (r <= 3) || (r == 8);
            wr = ((r >= 4) && (r <= 7)) || (r == 8);
            if ($urandom_range(0, 9) != 0) f3 = 3'(legal_f3[$urandom_range(0, 4)]);
            else                           f3 = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
            end
            issue(rd, wr, f3, a, $urandom);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
